// File: rtl/if_fetch_buffer_pkg.sv
// if_fetch_buffer_pkg: shared widths, NOP encoding and the fetch FIFO entry type
// Contents: XLEN, NOP_INST, fetch_entry_t {pc, inst, misalign}
package if_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            misalign;
    } fetch_entry_t;
endpackage

// File: rtl/if_fetch_buffer_if.sv
// if_fetch_buffer_if: instruction-memory and IF/ID handshake bundle
// imem_*: request/grant/response to instruction memory
// out_*:  valid/ready head entry toward the IF/ID register
// master = fetch buffer side, slave = memory/pipeline side
interface if_fetch_buffer_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_misalign;
    modport master (
        output imem_req, imem_addr, out_valid, out_pc, out_inst, out_misalign,
        input  imem_gnt, imem_rvalid, imem_rdata, out_ready
    );
    modport slave (
        input  imem_req, imem_addr, out_valid, out_pc, out_inst, out_misalign,
        output imem_gnt, imem_rvalid, imem_rdata, out_ready
    );
endinterface

// File: rtl/if_fetch_buffer_fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch entries with flush
// clk/rst: clock, async active-high reset
// flush: empties the FIFO, overriding push/pop
// push/din: write entry; pop: advance head; head/count: current head and occupancy
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: instruction-fetch front end between PC register and IF/ID
// clk, rst: clock, async active-high reset
// pc_in: current PC; pc_ce: PC register enable; redirect: branch/jump taken
// bus (master): imem request/grant/response and out valid/ready head entry
// Optional: define FETCH_MISALIGN_CHK_EN to turn misaligned PCs into NOP entries
module if_fetch_buffer
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_ce,
    input  logic            redirect,
    if_fetch_buffer_if.master bus
);
`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic MIS_EN = 1'b1;
`else
    localparam logic MIS_EN = 1'b0;
`endif
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0]   count;
    logic            pending, drop;
    logic [XLEN-1:0] pend_pc;
    logic            misalign, mis_push, accept, resp_push, pop;
    fetch_entry_t    push_data, head;
    assign misalign  = MIS_EN && (pc_in[1:0] != 2'b00);
    // Credit counts the in-flight fetch so a response always has a free slot
    assign bus.imem_req  = !rst && !redirect && !misalign && ((int'(count) + int'(pending)) < DEPTH);
    assign bus.imem_addr = pc_in;
    assign accept    = bus.imem_req && bus.imem_gnt;
    // Misaligned PCs bypass memory; waiting for pending keeps FIFO order
    assign mis_push  = !rst && !redirect && misalign && !pending && (int'(count) < DEPTH);
    assign resp_push = bus.imem_rvalid && pending && !drop && !redirect;
    assign pop       = bus.out_valid && bus.out_ready && !redirect;
    assign pc_ce     = accept || redirect || mis_push;
    always_comb
        push_data = resp_push ? fetch_entry_t'{pc: pend_pc, inst: bus.imem_rdata, misalign: 1'b0}
                              : fetch_entry_t'{pc: pc_in, inst: NOP_INST, misalign: 1'b1};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            drop    <= 1'b0;
            pend_pc <= '0;
        end else begin
            pending <= accept || (pending && !bus.imem_rvalid);
            // Only a response still outstanding after the redirect needs dropping
            drop    <= redirect ? (pending && !bus.imem_rvalid) : (drop && !(pending && bus.imem_rvalid));
            if (accept) pend_pc <= pc_in;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (resp_push || mis_push),
        .pop   (pop),
        .din   (push_data),
        .head  (head),
        .count (count)
    );
    assign bus.out_valid    = count != '0;
    assign bus.out_pc       = head.pc;
    assign bus.out_inst     = head.inst;
    assign bus.out_misalign = head.misalign && MIS_EN;
endmodule

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
- Instruction-fetch front end that sits between the 32-bit PC register and the IF/ID pipeline register.
- Drives the PC register's clock-enable: the PC advances only when a fetch is accepted or a redirect occurs.
- Issues requests to instruction memory and buffers returned {pc, inst} pairs in a small FIFO, so downstream stalls never lose instructions.
- Squashes buffered and in-flight fetches on a branch/jump redirect.

Parameters:
- DEPTH, 2, number of FIFO entries (power of two, ≥2).
- XLEN, 32, address/instruction width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- pc_in  input  XLEN  current PC (PC register Q).
- pc_ce  output  1  clock-enable to the PC register.
- redirect  input  1  branch/jump taken; the PC register loads the target this cycle.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address, equal to pc_in.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid, exactly 1 cycle after the grant.
- imem_rdata  input  XLEN  instruction word.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  IF/ID register accepts the head.
- out_pc  output  XLEN  PC of the head entry.
- out_inst  output  XLEN  instruction of the head entry.
- out_misalign  output  1  head-entry misalign flag (see Optional Feature).

Behaviour:
- Reset (async, rst=1): FIFO count=0, rd/wr pointers=0, pending=0, drop=0. Outputs: out_valid=0, imem_req=0, pc_ce=0, out_pc=0, out_inst=0, out_misalign=0.
- Credit rule:
  - imem_req = !rst && !redirect && (count + pending < DEPTH).
  - Pops in the same cycle do not add credit; the rule is evaluated on registered count only.
- Accept:
  - A fetch is accepted when imem_req && imem_gnt.
  - On accept: pending<=1 and pend_pc<=pc_in.
  - pc_ce = accept || redirect (combinational).
- Response:
  - On imem_rvalid with pending=1 and drop=0, push {pend_pc, imem_rdata} at wr_ptr.
  - pending clears unless a new accept occurs in the same cycle; back-to-back accepts give one fetch per cycle.
  - imem_rvalid with pending=0 is a protocol error and is ignored.
- Output:
  - out_valid = (count != 0); out_pc/out_inst/out_misalign come from the rd_ptr entry.
  - Pop on out_valid && out_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. Push is never attempted when full; the credit rule guarantees this.
- Pointer wrap: mod DEPTH.
- Redirect:
  - Next cycle count=0, pointers=0, out_valid=0.
  - If pending, set drop=1; the matching rvalid is discarded and drop clears.
  - imem_req=0 during the redirect cycle.
  - Redirect overrides any push or pop in the same cycle.
- Latency: PC accepted in cycle N → out_valid in cycle N+2 when the FIFO was empty.
- Reset mid-operation: all state is cleared immediately, and any in-flight response is ignored because pending=0.

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - When pc_in[1:0]!=0, imem_req stays 0.
  - Instead, if count<DEPTH and pending=0, an entry {pc_in, 32'h00000013, misalign=1} is pushed directly and pc_ce=1.
  - out_misalign reflects the head entry.
- Undefined:
  - pc_in[1:0] is ignored and imem_addr=pc_in unmodified.
  - out_misalign is tied 0.

Decomposition:
- Shared package if_pkg: XLEN, NOP_INST=32'h00000013, typedef fetch_entry_t {pc, inst, misalign}.
- One sub-module, fetch_fifo: parameterised DEPTH-entry synchronous FIFO with flush, push, pop, count and head outputs.
- The credit, pending and drop logic stays in the top module.

Test Plan:
- Streaming, out_ready=1, gnt=1, pc_in=0x0,0x4,0x8 → pc_ce high each cycle; out_pc=0x0/0x4/0x8 in cycles 2/3/4 with the matching rdata.
- Back-pressure, out_ready=0 → after two accepts imem_req=0 and pc_ce=0. Release out_ready → entries emitted in order and fetching resumes; no instruction lost or duplicated.
- Redirect while pending=1 and count=1 → out_valid=0 next cycle; the late rvalid (rdata=0xDEADBEEF) is dropped and never appears at out_inst.
- gnt=0 for 3 cycles → imem_req held, pc_ce=0, pc_in stable; the fetch is accepted in cycle 4.
- rst asserted mid-stream with count=2 → out_valid=0 asynchronously; after release the first output is the new pc_in.
- With FETCH_MISALIGN_CHK_EN, pc_in=0x00000102 → no imem_req; the entry is output with out_misalign=1 and out_inst=0x00000013.
